instruction_fetch_unit: RTL

//  Fetch stage directly upstream of the control unit. Owns the program counter, the instruction MAR,
//  the instruction-memory request/ack handshake and the instruction register. Its instruction output
//  is the control unit's instruction input. It executes the control unit's strobes: signal_PC,

---
 rtl/instruction_fetch_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: program counter, instruction MAR, imem request/ack handshake and
// instruction register feeding the control unit.
module instruction_fetch_unit #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              signal_PC,
    input  logic              signal_PC_sel,
    input  logic              signal_I_MAR,
    input  logic              signal_read_I_mem,
    input  logic              signal_IR,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_busy,
    output logic              fetch_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              ir_armed_q, ir_armed_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              err_q, err_d;
    logic              req_q, req_d;

    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] addr_sel;
    logic [WD_W-1:0]   wdog_inc;

    // Jump target comes from the IR as it stood before this edge.
    assign target   = instr_q[ADDR_W-1:0];
    assign addr_sel = (signal_PC && signal_PC_sel) ? target : pc_q;
    assign wdog_inc = wdog_q + WD_W'(1);

    // Next-state, PC/MAR update, IR capture and watchdog.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mar_d      = mar_q;
        instr_d    = instr_q;
        ir_armed_d = ir_armed_q | signal_IR;
        wdog_d     = wdog_q;
        err_d      = err_q;

        // PC keeps moving even while a read is outstanding.
        if (signal_PC) begin
            pc_d = addr_sel + ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (signal_I_MAR) begin
                    mar_d = addr_sel;
                end
                if (signal_read_I_mem) begin
                    state_d = REQ;
                    wdog_d  = '0;
                end
            end
            REQ: begin
                // MAR is frozen here so imem_addr stays stable for the whole request.
                if (imem_ack) begin
                    state_d    = IDLE;
                    wdog_d     = '0;
                    ir_armed_d = 1'b0;
                    if (ir_armed_q || signal_IR) begin
                        instr_d = imem_rdata;
                    end
                end else if (wdog_inc == WD_W'(TIMEOUT)) begin
                    state_d    = IDLE;
                    wdog_d     = '0;
                    ir_armed_d = 1'b0;
                    err_d      = 1'b1;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_d = (state_d == REQ);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= ADDR_W'(RESET_PC);
            mar_q      <= ADDR_W'(RESET_PC);
            instr_q    <= '0;
            ir_armed_q <= 1'b0;
            wdog_q     <= '0;
            err_q      <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mar_q      <= mar_d;
            instr_q    <= instr_d;
            ir_armed_q <= ir_armed_d;
            wdog_q     <= wdog_d;
            err_q      <= err_d;
            req_q      <= req_d;
        end
    end

    assign imem_addr   = mar_q;
    assign imem_req    = req_q;
    assign fetch_busy  = req_q;
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign fetch_err   = err_q;

endmodule
